// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with bubble insertion and EX operand forwarding muxes
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_stall,
    input  logic                flush,
    input  logic                load_use_nop,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          id_rd,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_pc_src,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                id_branch,
    input  logic                id_jump,
    input  logic                mem_wb_reg_write,
    input  logic [4:0]          mem_wb_rd,
    input  logic [XLEN-1:0]     mem_wb_write_data,
    input  logic [XLEN-1:0]     ex_mem_alu_result,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_imm,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [4:0]          ex_rd,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [XLEN-1:0]     ex_op_a,
    output logic [XLEN-1:0]     ex_op_b,
    output logic [XLEN-1:0]     ex_store_data,
    output logic [15:0]         bubble_cnt,
    output logic [15:0]         flush_cnt
);
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                branch;
        logic                jump;
        logic                pc_src;
        logic                alu_src;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_t;

    ex_t             q, d;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            wb_hit1, wb_hit2;

    // WB writes the register file in the same cycle ID reads it, so take the WB value directly
    assign wb_hit1 = mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_rs1;
    assign wb_hit2 = mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_rs2;

    // Next pipeline contents when loading from ID
    always_comb begin
        d = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
              mem_write: id_mem_write, mem_to_reg: id_mem_to_reg, branch: id_branch,
              jump: id_jump, pc_src: id_pc_src, alu_src: id_alu_src, pc: id_pc,
              imm: id_imm, rs1_data: wb_hit1 ? mem_wb_write_data : id_rs1_data,
              rs2_data: wb_hit2 ? mem_wb_write_data : id_rs2_data, rs1: id_rs1,
              rs2: id_rs2, rd: id_rd, alu_op: id_alu_op};
    end

    // Pipeline register: stall holds, flush or load-use NOP inserts an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!mem_stall)
            q <= (flush || load_use_nop) ? '0 : d;
    end

    // Saturating event counters; a combined flush+nop counts only as a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!mem_stall) begin
            if (flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
            if (!flush && load_use_nop && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_mem_to_reg = q.mem_to_reg;
    assign ex_branch     = q.branch;
    assign ex_jump       = q.jump;
    assign ex_pc         = q.pc;
    assign ex_imm        = q.imm;
    assign ex_rs1        = q.rs1;
    assign ex_rs2        = q.rs2;
    assign ex_rd         = q.rd;
    assign ex_alu_op     = q.alu_op;

    assign fwd_rs1 = fwd_a == 2'b10 ? ex_mem_alu_result : fwd_a == 2'b01 ? mem_wb_write_data : q.rs1_data;
    assign fwd_rs2 = fwd_b == 2'b10 ? ex_mem_alu_result : fwd_b == 2'b01 ? mem_wb_write_data : q.rs2_data;

    assign ex_op_a       = q.pc_src ? q.pc : fwd_rs1;
    assign ex_op_b       = q.alu_src ? q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int AW   = 4;

    logic            clk, rst, mem_stall, flush, load_use_nop, id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd, mem_wb_rd;
    logic [AW-1:0]   id_alu_op;
    logic            id_alu_src, id_pc_src, id_reg_write, id_mem_read, id_mem_write;
    logic            id_mem_to_reg, id_branch, id_jump, mem_wb_reg_write;
    logic [XLEN-1:0] mem_wb_write_data, ex_mem_alu_result;
    logic [1:0]      fwd_a, fwd_b;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic            ex_branch, ex_jump;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_op_a, ex_op_b, ex_store_data;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [AW-1:0]   ex_alu_op;
    logic [15:0]     bubble_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(AW)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .load_use_nop(load_use_nop),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_pc_src(id_pc_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .id_jump(id_jump), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_write_data(mem_wb_write_data),
        .ex_mem_alu_result(ex_mem_alu_result), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction currently held in EX, plus plain event tallies
    typedef struct {
        bit              valid, rw, mr, mw, m2r, br, jp, pc_src, alu_src;
        bit [XLEN-1:0]   pc, imm, a, b;
        bit [4:0]        rs1, rs2, rd;
        bit [AW-1:0]     op;
    } instr_t;

    instr_t m;
    int     n_bubbles, n_flushes;

    function automatic bit [XLEN-1:0] reg_read(input bit [4:0] idx, input bit [XLEN-1:0] rf);
        if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == idx) return mem_wb_write_data;
        return rf;
    endfunction

    function automatic bit [XLEN-1:0] operand(input bit [1:0] sel, input bit [XLEN-1:0] own);
        case (sel)
            2'd2:    return ex_mem_alu_result;
            2'd1:    return mem_wb_write_data;
            default: return own;
        endcase
    endfunction

    function automatic bit [15:0] sat(input int n);
        return n > 65535 ? 16'hFFFF : n[15:0];
    endfunction

    always @(posedge clk) begin
        instr_t nxt;
        if (rst) begin
            nxt = '{default: 0};
            m = nxt;
            n_bubbles = 0;
            n_flushes = 0;
        end else if (!mem_stall) begin
            if (flush) n_flushes++;
            else if (load_use_nop) n_bubbles++;
            nxt = '{default: 0};
            if (!flush && !load_use_nop) begin
                nxt.valid = id_valid; nxt.rw = id_reg_write; nxt.mr = id_mem_read;
                nxt.mw = id_mem_write; nxt.m2r = id_mem_to_reg; nxt.br = id_branch;
                nxt.jp = id_jump; nxt.pc_src = id_pc_src; nxt.alu_src = id_alu_src;
                nxt.pc = id_pc; nxt.imm = id_imm; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
                nxt.rd = id_rd; nxt.op = id_alu_op;
                nxt.a = reg_read(id_rs1, id_rs1_data);
                nxt.b = reg_read(id_rs2, id_rs2_data);
            end
            m = nxt;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        chk("valid", ex_valid, m.valid);
        chk("reg_write", ex_reg_write, m.rw);
        chk("mem_read", ex_mem_read, m.mr);
        chk("mem_write", ex_mem_write, m.mw);
        chk("mem_to_reg", ex_mem_to_reg, m.m2r);
        chk("branch", ex_branch, m.br);
        chk("jump", ex_jump, m.jp);
        chk("pc", ex_pc, m.pc);
        chk("imm", ex_imm, m.imm);
        chk("rs1", ex_rs1, m.rs1);
        chk("rs2", ex_rs2, m.rs2);
        chk("rd", ex_rd, m.rd);
        chk("alu_op", ex_alu_op, m.op);
        chk("op_a", ex_op_a, m.pc_src ? m.pc : operand(fwd_a, m.a));
        chk("op_b", ex_op_b, m.alu_src ? m.imm : operand(fwd_b, m.b));
        chk("store_data", ex_store_data, operand(fwd_b, m.b));
        chk("bubble_cnt", bubble_cnt, sat(n_bubbles));
        chk("flush_cnt", flush_cnt, sat(n_flushes));
    end

    task automatic rand_id();
        id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
        id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom); id_alu_op = AW'($urandom);
        id_alu_src = 1'($urandom); id_pc_src = 1'($urandom); id_reg_write = 1'($urandom);
        id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
        id_branch = 1'($urandom); id_jump = 1'($urandom);
        mem_wb_reg_write = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 3));
        mem_wb_write_data = $urandom; ex_mem_alu_result = $urandom;
        fwd_a = 2'($urandom); fwd_b = 2'($urandom);
    endtask

    initial begin
        rst = 1; mem_stall = 1; flush = 1; load_use_nop = 1;
        rand_id();
        id_valid = 1; id_pc = 32'h1234; id_rd = 5'd9; id_reg_write = 1; id_mem_read = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset pc", ex_pc, 0);
        chk("reset valid", ex_valid, 0);
        chk("reset bubble_cnt", bubble_cnt, 0);
        rst = 0; mem_stall = 1; id_pc = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        chk("stalled pc", ex_pc, 0);
        chk("stalled flush_cnt", flush_cnt, 0);
        mem_stall = 0; flush = 0; load_use_nop = 0;
        @(negedge clk);
        #1;
        chk("first load pc", ex_pc, 32'h100);

        id_rs1_data = 32'h11; id_imm = 32'h20; id_alu_src = 1; id_pc_src = 0;
        id_rs1 = 5'd3; mem_wb_reg_write = 0;
        @(negedge clk);
        mem_stall = 1; fwd_a = 2'b10; ex_mem_alu_result = 32'hAA;
        #1;
        chk("fwd_a=10 op_a", ex_op_a, 32'hAA);
        chk("alu_src op_b", ex_op_b, 32'h20);
        fwd_a = 2'b11;
        #1;
        chk("fwd_a=11 op_a", ex_op_a, 32'h11);

        mem_stall = 0; id_rs2 = 5'd5; id_rs2_data = 32'h1; fwd_b = 2'b00;
        mem_wb_reg_write = 1; mem_wb_rd = 5'd5; mem_wb_write_data = 32'h77;
        @(negedge clk);
        mem_stall = 1;
        #1;
        chk("wb write-through", ex_store_data, 32'h77);
        mem_stall = 0; mem_wb_rd = 5'd0;
        @(negedge clk);
        mem_stall = 1;
        #1;
        chk("no write-through x0", ex_store_data, 32'h1);

        mem_stall = 0; load_use_nop = 1; id_valid = 1; id_mem_write = 1; id_rd = 5'd7;
        @(negedge clk);
        load_use_nop = 0; mem_stall = 1;
        #1;
        chk("nop valid", ex_valid, 0);
        chk("nop mem_write", ex_mem_write, 0);
        chk("nop rd", ex_rd, 0);
        chk("nop bubble_cnt", bubble_cnt, 1);

        mem_stall = 0; flush = 1; load_use_nop = 1;
        @(negedge clk);
        mem_stall = 1;
        #1;
        chk("flush+nop flush_cnt", flush_cnt, 1);
        chk("flush+nop bubble_cnt", bubble_cnt, 1);
        @(negedge clk);
        #1;
        chk("stalled flush_cnt", flush_cnt, 1);
        chk("stalled bubble_cnt", bubble_cnt, 1);
        flush = 0; load_use_nop = 0; mem_stall = 0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rand_id();
            rst = ($urandom_range(0, 199) == 0);
            mem_stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            load_use_nop = ($urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        rst = 1; mem_stall = 0; flush = 0; load_use_nop = 0;
        @(negedge clk);
        rst = 0; load_use_nop = 1;
        repeat (65534) @(negedge clk);
        #1;
        chk("bubble_cnt 0xFFFE", bubble_cnt, 16'hFFFE);
        repeat (2) @(negedge clk);
        #1;
        chk("bubble_cnt saturated", bubble_cnt, 16'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        chk("bubble_cnt holds", bubble_cnt, 16'hFFFF);
        chk("flush_cnt untouched", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage core, plus the EX-side operand forwarding muxes.
- Captures decoded fields from ID and inserts bubbles on load-use hazard or flush.
- Feeds registered rs1/rs2/rd/mem_read to the forwarding unit.
- Consumes the forwarding unit's fwd_a/fwd_b selects to produce the ALU operands and store data.

Parameters:
XLEN, 32, datapath width
ALU_OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
mem_stall  in  1  downstream freeze; hold all state
flush  in  1  taken branch/jump from EX; bubble next cycle
load_use_nop  in  1  NOP from forwarding unit; bubble next cycle
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_alu_op  in  ALU_OP_W  ALU opcode
id_alu_src  in  1  1: op_b = imm
id_pc_src  in  1  1: op_a = pc (auipc/jal)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_jump  in  1 each  control bits
mem_wb_reg_write  in  1  WB writes register file this cycle
mem_wb_rd  in  5  WB destination
mem_wb_write_data  in  XLEN  WB data (also forward source 01)
ex_mem_alu_result  in  XLEN  forward source 10
fwd_a, fwd_b  in  2  forwarding selects
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump  out  1 each  registered control
ex_pc, ex_imm  out  XLEN  registered
ex_rs1, ex_rs2, ex_rd  out  5  registered; ex_rs1/ex_rs2/ex_rd/ex_mem_read go to the forwarding unit
ex_alu_op  out  ALU_OP_W  registered
ex_op_a, ex_op_b, ex_store_data  out  XLEN  combinational operands
bubble_cnt, flush_cnt  out  16  saturating event counters

Behaviour:
- Reset (async, immediate): all registered outputs and both counters = 0. ex_op_a/ex_op_b/ex_store_data therefore evaluate to 0 while fwd = 00.
- Per-edge update priority: rst > mem_stall > flush > load_use_nop > load.
  - mem_stall=1: every register, counters included, holds its value. flush and load_use_nop are ignored.
  - flush=1 or load_use_nop=1 (mem_stall=0): bubble. All registered fields = 0 (valid, control bits, indices, data).
  - Otherwise: load all id_* fields into ex_* registers; latency 1 cycle.
- WB write-through on load: if mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==id_rs1, capture mem_wb_write_data instead of id_rs1_data. Same rule for rs2. Applies even when id_valid=0.
- Forward mux, combinational on registered data:
  - fwd=10 selects ex_mem_alu_result.
  - fwd=01 selects mem_wb_write_data.
  - fwd=00 or 11 selects registered rs data.
  - fwd_a forms fwd_rs1; fwd_b forms fwd_rs2.
- Operand selection:
  - ex_op_a = ex_pc_src ? ex_pc : fwd_rs1 (ex_pc_src is a registered copy of id_pc_src).
  - ex_op_b = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of alu_src.
- Counters, updated on non-stalled edges only:
  - bubble_cnt +1 when load_use_nop=1 and flush=0.
  - flush_cnt +1 when flush=1 (flush and nop together count once, as flush).
  - Both saturate at 16'hFFFF, no wrap.
- Bubble index fields are 0. ex_rd=0 and ex_reg_write=0 guarantee no forwarding from a bubble; ex_mem_read=0 guarantees no chained load-use stall.
- Reset asserted mid-operation clears state immediately; first load occurs on the first edge after deassertion.

Test Plan:
- Reset with all inputs nonzero, then release with mem_stall=1 for 2 cycles -> all ex_* and counters stay 0; first free edge loads id_pc=0x100 into ex_pc.
- Load id_rs1_data=0x11, id_imm=0x20, alu_src=1, then fwd_a=10 with ex_mem_alu_result=0xAA -> ex_op_a=0xAA, ex_op_b=0x20; fwd_a=11 -> ex_op_a=0x11.
- id_rs2=5, id_rs2_data=0x1, mem_wb_reg_write=1, mem_wb_rd=5, mem_wb_write_data=0x77 on load edge -> ex_store_data=0x77 with fwd_b=00. Repeat with mem_wb_rd=0 -> ex_store_data=0x1.
- load_use_nop=1 one cycle with valid store in ID -> next cycle ex_valid=0, ex_mem_write=0, ex_rd=0, bubble_cnt=1.
- flush=1 and load_use_nop=1 together -> bubble, flush_cnt=1, bubble_cnt unchanged. Same with mem_stall=1 -> no change at all.
- Preload bubble_cnt to 0xFFFE via 2 further nops -> counter holds 0xFFFF.
